// File: rtl/counter_sample_capture.sv
// Capture FIFO for the counter selector output: stores {sel,value} samples,
// drains them through a show-ahead valid/ready port, and flags threshold hits and drops.
module counter_sample_capture #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      cap_en,
    input  logic [DATA_W-1:0]         thr,
    input  logic                      clr_ovf,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W+DATA_W-1:0]   out_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic                      thr_hit
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = SEL_W + DATA_W;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             thr_hit_q, thr_hit_d;
    logic             push, pop, drop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_DEPTH);
    assign out_valid = ~empty;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign thr_hit   = thr_hit_q;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop  = out_valid & out_ready;
        // A full FIFO still accepts a capture when the head leaves in the same cycle.
        push = cap_en & (~full | pop);
        drop = cap_en & full & ~pop;

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)
            overflow_d = 1'b1;
        else if (clr_ovf)
            overflow_d = 1'b0;
        else
            overflow_d = overflow_q;

        thr_hit_d = cap_en & (in_data == thr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            thr_hit_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            thr_hit_q  <= thr_hit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {in_sel, in_data};
    end

endmodule
